// File: rtl/writeback_stage.sv
// Final pipeline stage: commits register, segment, MMX, ESP and memory results,
// raises fetch redirects on misprediction and counts retired instructions.
module writeback_stage #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_dest_address,
  input  logic [2:0]        wb_dest_reg,
  input  logic [63:0]       wb_result,
  input  logic [2:0]        wb_opsize,
  input  logic              wb_mem_or_reg,
  input  logic              wb_op_a_is_segment,
  input  logic              wb_op_a_is_mmx,
  input  logic [1:0]        wb_stack_op,
  input  logic              wb_br_misprediction,
  input  logic [31:0]       wb_jump_address,
  input  logic [31:0]       esp_in,
  output logic              rf_we,
  output logic [2:0]        rf_sel,
  output logic [1:0]        rf_size,
  output logic [31:0]       rf_data,
  output logic              seg_we,
  output logic              mmx_we,
  output logic [63:0]       mmx_data,
  output logic              esp_we,
  output logic [31:0]       esp_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_address,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {IDLE, MEM_LO, MEM_HI} state_t;
  state_t state, state_nxt;

  logic              accept;
  logic              is_push;
  logic              is_pop;
  logic              is_mem_op;
  logic              mem_done;
  logic [31:0]       esp_step;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       lat_result;
  logic              lat_qword;
  logic [3:0]        lat_be;
  logic              lat_esp_upd;
  logic [31:0]       lat_esp_new;

  assign wb_ready  = reset && (state == IDLE);
  assign accept    = wb_valid && wb_ready && !flush;
  assign is_push   = (wb_stack_op == 2'b01);
  assign is_pop    = (wb_stack_op == 2'b10);
  assign is_mem_op = wb_mem_or_reg || is_push;
  assign esp_step  = (wb_opsize == 3'd1) ? 32'd2 : 32'd4;
  assign mem_done  = mem_ack && ((state == MEM_HI) || ((state == MEM_LO) && !lat_qword));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      IDLE: begin
        if (accept && is_mem_op) state_nxt = MEM_LO;
      end
      MEM_LO: begin
        mem_req   = 1'b1;
        mem_addr  = lat_addr;
        mem_wdata = lat_result[31:0];
        mem_be    = lat_be;
        if (mem_ack) state_nxt = lat_qword ? MEM_HI : IDLE;
      end
      MEM_HI: begin
        mem_req   = 1'b1;
        mem_addr  = lat_addr + ADDR_W'(4);
        mem_wdata = lat_result[63:32];
        mem_be    = 4'hF;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we            <= 1'b0;
      rf_sel           <= '0;
      rf_size          <= '0;
      rf_data          <= '0;
      seg_we           <= 1'b0;
      mmx_we           <= 1'b0;
      mmx_data         <= '0;
      esp_we           <= 1'b0;
      esp_data         <= '0;
      redirect_valid   <= 1'b0;
      redirect_address <= '0;
      retired_count    <= '0;
      lat_addr         <= '0;
      lat_result       <= '0;
      lat_qword        <= 1'b0;
      lat_be           <= '0;
      lat_esp_upd      <= 1'b0;
      lat_esp_new      <= '0;
    end else begin
      rf_we          <= 1'b0;
      seg_we         <= 1'b0;
      mmx_we         <= 1'b0;
      esp_we         <= 1'b0;
      redirect_valid <= 1'b0;
      if (accept) begin
        // Push addresses come from the stack pointer, not the bundle address
        lat_addr    <= is_push ? ADDR_W'(esp_in - esp_step) : ADDR_W'(wb_dest_address);
        lat_result  <= wb_result;
        lat_qword   <= (wb_opsize == 3'd3);
        lat_be      <= (wb_opsize == 3'd0) ? 4'b0001 :
                       (wb_opsize == 3'd1) ? 4'b0011 : 4'b1111;
        lat_esp_upd <= is_push || is_pop;
        lat_esp_new <= is_push ? (esp_in - esp_step) : (esp_in + esp_step);
        if (wb_br_misprediction) begin
          redirect_valid   <= 1'b1;
          redirect_address <= ADDR_W'(wb_jump_address);
        end
        if (!is_mem_op) begin
          rf_sel        <= wb_dest_reg;
          rf_size       <= wb_opsize[1:0];
          rf_data       <= wb_result[31:0];
          mmx_data      <= wb_result;
          mmx_we        <= wb_op_a_is_mmx;
          seg_we        <= !wb_op_a_is_mmx && wb_op_a_is_segment;
          rf_we         <= !wb_op_a_is_mmx && !wb_op_a_is_segment;
          retired_count <= retired_count + CNT_W'(1);
          if (is_pop) begin
            esp_we   <= 1'b1;
            esp_data <= esp_in + esp_step;
          end
        end
      end
      if (mem_done) begin
        retired_count <= retired_count + CNT_W'(1);
        if (lat_esp_upd) begin
          esp_we   <= 1'b1;
          esp_data <= lat_esp_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: register commits, memory beats,
// stack ops, flush, redirect and reset behaviour.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, flush, wb_valid, wb_ready;
  logic [31:0] wb_dest_address, wb_jump_address, esp_in;
  logic [2:0]  wb_dest_reg, wb_opsize;
  logic [63:0] wb_result;
  logic        wb_mem_or_reg, wb_op_a_is_segment, wb_op_a_is_mmx, wb_br_misprediction;
  logic [1:0]  wb_stack_op;
  logic        rf_we, seg_we, mmx_we, esp_we, mem_req, mem_ack, redirect_valid;
  logic [2:0]  rf_sel;
  logic [1:0]  rf_size;
  logic [31:0] rf_data, esp_data, mem_addr, mem_wdata, redirect_address, retired_count;
  logic [63:0] mmx_data;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} beat_t;
  typedef struct {int kind; logic [2:0] sel; logic [63:0] data;} rf_exp_t;
  beat_t   exp_beats[$];
  rf_exp_t exp_regs[$];

  writeback_stage #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_address(wb_dest_address), .wb_dest_reg(wb_dest_reg), .wb_result(wb_result),
    .wb_opsize(wb_opsize), .wb_mem_or_reg(wb_mem_or_reg),
    .wb_op_a_is_segment(wb_op_a_is_segment), .wb_op_a_is_mmx(wb_op_a_is_mmx),
    .wb_stack_op(wb_stack_op), .wb_br_misprediction(wb_br_misprediction),
    .wb_jump_address(wb_jump_address), .esp_in(esp_in),
    .rf_we(rf_we), .rf_sel(rf_sel), .rf_size(rf_size), .rf_data(rf_data),
    .seg_we(seg_we), .mmx_we(mmx_we), .mmx_data(mmx_data),
    .esp_we(esp_we), .esp_data(esp_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .redirect_valid(redirect_valid),
    .redirect_address(redirect_address), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bundle();
    flush = 0; wb_valid = 0; wb_dest_address = 0; wb_dest_reg = 0; wb_result = 0;
    wb_opsize = 0; wb_mem_or_reg = 0; wb_op_a_is_segment = 0; wb_op_a_is_mmx = 0;
    wb_stack_op = 0; wb_br_misprediction = 0; wb_jump_address = 0; esp_in = 0;
  endtask

  task automatic test_reset();
    reset = 0; mem_ack = 0;
    clear_bundle();
    tick(); tick();
    checks++;
    if ({rf_we, seg_we, mmx_we, esp_we, mem_req, redirect_valid} !== 6'b0 ||
        mem_addr !== 0 || rf_data !== 0 || redirect_address !== 0 || retired_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs strobes=%b mem_addr=%h rf_data=%h cnt=%0d required all zero",
               {rf_we, seg_we, mmx_we, esp_we, mem_req, redirect_valid}, mem_addr, rf_data, retired_count);
    end
    reset = 1;
    #1;
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b required 1", wb_ready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_reg_write();
    rf_exp_t e;
    wb_valid = 1; wb_dest_reg = 3; wb_result = 64'h00000000_DEADBEEF; wb_opsize = 2;
    exp_regs.push_back('{0, 3'd3, 64'h00000000_DEADBEEF});
    exp_cnt++;
    tick();
    clear_bundle();
    e = exp_regs.pop_front();
    checks++;
    if (rf_we !== 1 || seg_we !== 0 || mmx_we !== 0 || rf_sel !== e.sel ||
        rf_data !== e.data[31:0] || rf_size !== 2'd2) begin
      errors++;
      $display("FAIL reg_write we=%b sel=%0d data=%h size=%0d required 1/%0d/%h/2",
               rf_we, rf_sel, rf_data, rf_size, e.sel, e.data[31:0]);
    end
    checks++;
    if (retired_count !== exp_cnt || wb_ready !== 1) begin
      errors++; $display("FAIL reg_count cnt=%0d ready=%b required %0d/1", retired_count, wb_ready, exp_cnt);
    end
    tick();
    checks++;
    if (rf_we !== 0) begin
      errors++; $display("FAIL reg_pulse rf_we=%b required 0", rf_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res [3] = '{64'h0000_0001_1111_2222, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0000_0000_0000_0023};
    rf_exp_t e;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_dest_reg = 3'(i + 4); wb_result = res[i]; wb_opsize = 2;
      wb_op_a_is_mmx = (i == 1); wb_op_a_is_segment = (i == 2);
      exp_regs.push_back('{i, 3'(i + 4), res[i]});
      exp_cnt++;
      tick();
      e = exp_regs.pop_front();
      checks++;
      if (rf_we !== (e.kind == 0) || mmx_we !== (e.kind == 1) || seg_we !== (e.kind == 2) ||
          rf_sel !== e.sel || rf_data !== e.data[31:0] || mmx_data !== e.data ||
          retired_count !== exp_cnt || wb_ready !== 1) begin
        errors++;
        $display("FAIL b2b_%0d rf/mmx/seg=%b%b%b sel=%0d mmx=%h cnt=%0d required kind %0d sel=%0d mmx=%h cnt=%0d",
                 i, rf_we, mmx_we, seg_we, rf_sel, mmx_data, retired_count, e.kind, e.sel, e.data, exp_cnt);
      end
    end
    clear_bundle();
    tick();
    checks++;
    if ({rf_we, seg_we, mmx_we} !== 3'b0 || retired_count !== exp_cnt) begin
      errors++; $display("FAIL b2b_idle strobes=%b cnt=%0d required 000/%0d", {rf_we, seg_we, mmx_we}, retired_count, exp_cnt);
    end
  endtask

  task automatic test_mem_write(input string name, input logic [31:0] addr, input logic [63:0] res,
                                input logic [2:0] size, input logic [1:0] stk, input logic [31:0] esp,
                                input int ack_delay, input logic exp_esp_we, input logic [31:0] exp_esp);
    beat_t b;
    logic [31:0] a;
    logic [3:0]  be;
    a  = (stk == 2'b01) ? esp - ((size == 3'd1) ? 32'd2 : 32'd4) : addr;
    be = (size == 3'd0) ? 4'h1 : (size == 3'd1) ? 4'h3 : 4'hF;
    exp_beats.push_back('{a, res[31:0], be});
    if (size == 3'd3) exp_beats.push_back('{a + 32'd4, res[63:32], 4'hF});
    wb_valid = 1; wb_dest_address = addr; wb_result = res; wb_opsize = size;
    wb_mem_or_reg = (stk != 2'b01); wb_stack_op = stk; esp_in = esp;
    tick();
    clear_bundle();
    esp_in = esp;
    while (exp_beats.size() > 0) begin
      b = exp_beats.pop_front();
      for (int d = 0; d <= ack_delay; d++) begin
        checks++;
        if (mem_req !== 1 || mem_addr !== b.addr || mem_wdata !== b.data || mem_be !== b.be ||
            wb_ready !== 0 || esp_we !== 0) begin
          errors++;
          $display("FAIL %s_beat req=%b addr=%h data=%h be=%h ready=%b required 1/%h/%h/%h/0",
                   name, mem_req, mem_addr, mem_wdata, mem_be, wb_ready, b.addr, b.data, b.be);
        end
        if (d == ack_delay) mem_ack = 1;
        tick();
      end
      mem_ack = 0;
    end
    exp_cnt++;
    checks++;
    if (mem_req !== 0 || wb_ready !== 1 || retired_count !== exp_cnt || rf_we !== 0) begin
      errors++;
      $display("FAIL %s_done req=%b ready=%b cnt=%0d rf_we=%b required 0/1/%0d/0",
               name, mem_req, wb_ready, retired_count, rf_we, exp_cnt);
    end
    checks++;
    if (esp_we !== exp_esp_we || (exp_esp_we && esp_data !== exp_esp)) begin
      errors++; $display("FAIL %s_esp we=%b data=%h required %b/%h", name, esp_we, esp_data, exp_esp_we, exp_esp);
    end
    tick();
  endtask

  task automatic test_pop();
    wb_valid = 1; wb_dest_reg = 2; wb_result = 64'h0000_0000_0000_BEEF; wb_opsize = 1;
    wb_stack_op = 2'b10; esp_in = 32'h3000;
    exp_cnt++;
    tick();
    clear_bundle();
    checks++;
    if (rf_we !== 1 || esp_we !== 1 || esp_data !== 32'h3002 || rf_size !== 2'd1 ||
        rf_data !== 32'h0000BEEF || mem_req !== 0 || retired_count !== exp_cnt) begin
      errors++;
      $display("FAIL pop rf_we=%b esp_we=%b esp=%h size=%0d req=%b cnt=%0d required 1/1/3002/1/0/%0d",
               rf_we, esp_we, esp_data, rf_size, mem_req, retired_count, exp_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    wb_valid = 1; flush = 1; wb_dest_reg = 1; wb_result = 64'h1234;
    tick();
    clear_bundle();
    checks++;
    if ({rf_we, seg_we, mmx_we, esp_we} !== 4'b0 || retired_count !== exp_cnt) begin
      errors++; $display("FAIL flush_idle strobes=%b cnt=%0d required 0000/%0d", {rf_we, seg_we, mmx_we, esp_we}, retired_count, exp_cnt);
    end
    wb_valid = 1; wb_mem_or_reg = 1; wb_dest_address = 32'h800; wb_result = 64'h0000_0000_0BAD_F00D; wb_opsize = 2;
    tick();
    clear_bundle();
    wb_valid = 1; flush = 1; wb_dest_reg = 6; wb_result = 64'h99;
    tick();
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h800 || mem_wdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL flush_mem_hold req=%b addr=%h data=%h required 1/800/0badf00d", mem_req, mem_addr, mem_wdata);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    clear_bundle();
    exp_cnt++;
    checks++;
    if (mem_req !== 0 || retired_count !== exp_cnt || rf_we !== 0) begin
      errors++; $display("FAIL flush_mem_done req=%b cnt=%0d rf_we=%b required 0/%0d/0", mem_req, retired_count, rf_we, exp_cnt);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    checks++;
    if (mem_req !== 0 || retired_count !== exp_cnt || wb_ready !== 1) begin
      errors++; $display("FAIL stray_ack req=%b cnt=%0d ready=%b required 0/%0d/1", mem_req, retired_count, wb_ready, exp_cnt);
    end
  endtask

  task automatic test_redirect();
    wb_valid = 1; wb_dest_reg = 0; wb_br_misprediction = 1; wb_jump_address = 32'h4040;
    exp_cnt++;
    tick();
    clear_bundle();
    checks++;
    if (redirect_valid !== 1 || redirect_address !== 32'h4040) begin
      errors++; $display("FAIL redirect valid=%b addr=%h required 1/4040", redirect_valid, redirect_address);
    end
    tick();
    checks++;
    if (redirect_valid !== 0) begin
      errors++; $display("FAIL redirect_pulse valid=%b required 0", redirect_valid);
    end
    wb_valid = 1; wb_mem_or_reg = 1; wb_dest_address = 32'h500; wb_result = 64'hAB;
    wb_opsize = 0; wb_br_misprediction = 1; wb_jump_address = 32'h7000;
    tick();
    clear_bundle();
    checks++;
    if (redirect_valid !== 1 || redirect_address !== 32'h7000 || mem_req !== 1 || mem_be !== 4'h1) begin
      errors++; $display("FAIL redirect_mem valid=%b addr=%h req=%b be=%h required 1/7000/1/1",
                         redirect_valid, redirect_address, mem_req, mem_be);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    exp_cnt++;
    checks++;
    if (redirect_valid !== 0 || mem_req !== 0 || retired_count !== exp_cnt) begin
      errors++; $display("FAIL redirect_mem_done valid=%b req=%b cnt=%0d required 0/0/%0d", redirect_valid, mem_req, retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    wb_valid = 1; wb_mem_or_reg = 1; wb_dest_address = 32'h900; wb_result = 64'h55; wb_opsize = 2;
    tick();
    clear_bundle();
    checks++;
    if (mem_req !== 1) begin
      errors++; $display("FAIL midop_start req=%b required 1", mem_req);
    end
    #2 reset = 0;
    #1;
    exp_cnt = 0;
    checks++;
    if (mem_req !== 0 || retired_count !== 0 || esp_we !== 0 || mem_addr !== 0) begin
      errors++; $display("FAIL midop_reset req=%b cnt=%0d esp_we=%b addr=%h required 0/0/0/0", mem_req, retired_count, esp_we, mem_addr);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    reset = 1;
    #1;
    checks++;
    if (wb_ready !== 1 || mem_req !== 0 || retired_count !== 0) begin
      errors++; $display("FAIL midop_release ready=%b req=%b cnt=%0d required 1/0/0", wb_ready, mem_req, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_back_to_back();
    test_mem_write("qword", 32'h1000, 64'h11223344_55667788, 3'd3, 2'b00, 32'h0, 2, 1'b0, 32'h0);
    test_mem_write("push", 32'h0, 64'h00000000_CAFEF00D, 3'd2, 2'b01, 32'h2000, 0, 1'b1, 32'h1FFC);
    test_mem_write("push_word", 32'h0, 64'h00000000_0000ABCD, 3'd1, 2'b01, 32'h2000, 1, 1'b1, 32'h1FFE);
    test_mem_write("byte", 32'h0604, 64'h00000000_000000EE, 3'd0, 2'b00, 32'h0, 1, 1'b0, 32'h0);
    test_pop();
    test_flush();
    test_redirect();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
